// File: rtl/bcd_7seg.sv
// bcd_7seg: free-running single-digit decimal counter (0..9) that drives one
// seven-segment display digit. A prescaler advances the digit once every
// CLK_FREQ clock cycles. Segments are active-low {g,f,e,d,c,b,a}, and only
// anode 0 is enabled.
module bcd_7seg #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] seg,
  output logic [7:0] an
);

  // Prescaler width. The counter always has at least one bit, even when
  // CLK_FREQ is 1 and $clog2 would return 0.
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [PW-1:0] PS_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PS_ZERO = PW'(0);
  localparam logic [PW-1:0] PS_ONE  = PW'(1);

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] DIGIT_ZERO = 4'd0;
  localparam logic [3:0] DIGIT_ONE  = 4'd1;

  localparam logic [7:0] AN_DIGIT0 = 8'b1111_1110;

  // Maps a BCD digit to its active-low segment pattern {g,f,e,d,c,b,a}.
  // Codes 10..15 cannot occur, but they decode to a blank display.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Returns the next decimal digit, wrapping 9 back to 0.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    logic [3:0] nd;
    if (d == DIGIT_MAX) begin
      nd = DIGIT_ZERO;
    end else begin
      nd = d + DIGIT_ONE;
    end
    return nd;
  endfunction

  logic [PW-1:0] prescaler;
  logic [3:0]    digit;
  logic          tick;

  // A tick fires on the final prescaler count of each CLK_FREQ-cycle period.
  always_comb begin
    tick = 1'b0;
    if (prescaler == PS_MAX) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

  // Prescaler: counts 0..CLK_FREQ-1. Reset takes priority over a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= PS_ZERO;
    end else if (tick) begin
      prescaler <= PS_ZERO;
    end else begin
      prescaler <= prescaler + PS_ONE;
    end
  end

  // Digit register: advances on each tick. Reset wins, so a reset that
  // lands on a tick edge leaves no partial increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= DIGIT_ZERO;
    end else if (tick) begin
      digit <= next_digit(digit);
    end else begin
      digit <= digit;
    end
  end

  // The segment decode depends only on the digit register, so seg changes
  // only on the edge where the digit changes.
  always_comb begin
    seg = decode_digit(digit);
  end

  // Single digit with no multiplexing: anode 0 stays enabled, even in reset.
  always_comb begin
    an = AN_DIGIT0;
  end

endmodule

// File: tb/tb_bcd_7seg.sv
// Self-checking bench for bcd_7seg. Three instances (CLK_FREQ = 10, 1 and the
// default) share one clock. A reference model counts the non-reset edges since
// the last reset edge, n. The expected digit is (n / CLK_FREQ) % 10.
module tb_bcd_7seg;

  localparam int F10  = 10;
  localparam int F1   = 1;
  localparam int FBIG = 100_000_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst10 = 1'b1;
  logic rst1  = 1'b1;
  logic rstb  = 1'b1;

  logic [6:0] seg10, seg1, segb;
  logic [7:0] an10, an1, anb;

  bcd_7seg #(.CLK_FREQ(F10)) dut10 (.clk(clk), .reset(rst10), .seg(seg10), .an(an10));
  bcd_7seg #(.CLK_FREQ(F1))  dut1  (.clk(clk), .reset(rst1),  .seg(seg1),  .an(an1));
  bcd_7seg                   dut_big (.clk(clk), .reset(rstb), .seg(segb), .an(anb));

  int checks = 0;
  int errors = 0;

  longint n10 = 0;
  longint n1  = 0;
  longint nb  = 0;

  logic [6:0] seg_tab [0:9];

  // Expected seg for an instance that has seen n counted edges.
  function automatic logic [6:0] exp_seg(input longint n, input longint f);
    return seg_tab[int'((n / f) % 10)];
  endfunction

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model and check every output 1 ns later.
  task automatic step();
    @(posedge clk);
    n10 = rst10 ? 0 : n10 + 1;
    n1  = rst1  ? 0 : n1  + 1;
    nb  = rstb  ? 0 : nb  + 1;
    #1;
    chk7("seg10_model", seg10, exp_seg(n10, F10));
    chk7("seg1_model",  seg1,  exp_seg(n1,  F1));
    chk7("segb_model",  segb,  exp_seg(nb,  FBIG));
    chk8("an10", an10, 8'b1111_1110);
    chk8("an1",  an1,  8'b1111_1110);
    chk8("anb",  anb,  8'b1111_1110);
  endtask

  initial begin
    int gap;
    int len;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

    // Reset for two edges.
    step();
    step();
    chk7("reset_seg10", seg10, 7'b1000000);
    chk8("reset_an10",  an10,  8'b1111_1110);
    rst10 = 1'b0;
    rst1  = 1'b0;
    rstb  = 1'b0;

    // First increment exactly 10 edges after release.
    repeat (9) step();
    chk7("pre_first_inc", seg10, 7'b1000000);
    step();
    chk7("first_inc", seg10, 7'b1111001);

    // Full sweep through 9 and the wrap back to 0 (the model checks each edge).
    repeat (89) step();
    chk7("sweep_nine", seg10, 7'b0010000);
    step();
    chk7("sweep_wrap", seg10, 7'b1000000);
    repeat (10) step();

    // Mid-count reset while digit = 5 and prescaler = 6.
    gap = int'((156 - (n10 % 100)) % 100);
    repeat (gap) step();
    chk7("at_56", seg10, 7'b0010010);
    rst10 = 1'b1;
    step();
    chk7("mid_reset", seg10, 7'b1000000);
    rst10 = 1'b0;
    repeat (9) step();
    chk7("mid_reset_hold", seg10, 7'b1000000);
    step();
    chk7("mid_reset_inc", seg10, 7'b1111001);

    // Reset on the edge where the prescaler would tick.
    repeat (12) step();
    gap = int'((19 - (n10 % 10)) % 10);
    repeat (gap) step();
    rst10 = 1'b1;
    step();
    chk7("tick_vs_reset", seg10, 7'b1000000);
    rst10 = 1'b0;
    step();
    chk7("tick_vs_reset_after", seg10, 7'b1000000);

    // Fast mode: the digit advances every clock.
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk7("fast_seq", seg1, seg_tab[k % 10]);
      chk8("fast_an", an1, 8'b1111_1110);
    end

    // Default-parameter instance: 27-bit prescaler, digit held at 0.
    checks++;
    assert ($bits(dut_big.prescaler) == 27) else begin
      errors++;
      $error("FAIL big_width: observed %0d expected %0d", $bits(dut_big.prescaler), 27);
    end

    // Randomized stretches with sporadic reset pulses.
    for (int r = 0; r < 30; r++) begin
      len = int'($urandom_range(1, 60));
      for (int c = 0; c < len; c++) begin
        rst10 = ($urandom_range(0, 31) == 0);
        rst1  = ($urandom_range(0, 15) == 0);
        step();
      end
      rst10 = 1'b0;
      rst1  = 1'b0;
    end

    chk7("big_hold", segb, 7'b1000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
